// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: decoder load/store codes and arbiter FSM states shared by the memory port logic
package mem_port_arbiter_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        DM_BUSY,
        IF_BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core-side fetch/data ports and single-port memory bus of the arbiter
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [2:0]  load_control;
    logic [1:0]  store_control;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        stall;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, load_control, store_control, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_valid, stall, bus_error,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, load_control, store_control, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_valid, stall, bus_error,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_port_arbiter_align.sv
// mem_lane_align: store byte-lane steering, load lane extraction/extension and alignment check
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  i_load_control,
    input  logic [1:0]  i_store_control,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_q,
    input  logic [1:0]  i_off_q,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic        w_st;
    logic        w_half_ld;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_st      = i_store_control != ST_NONE;
    assign w_half_ld = i_load_control == LD_LH || i_load_control == LD_LHU;

    assign o_be = i_store_control == ST_SB ? 4'b0001 << i_addr_lo :
                  i_store_control == ST_SH ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign o_wdata = i_store_control == ST_SB ? {4{i_wdata[7:0]}} :
                     i_store_control == ST_SH ? {2{i_wdata[15:0]}} : i_wdata;

    // A store overrides any simultaneous load code, so only its size matters
    assign o_misaligned = w_st ? ((i_store_control == ST_SH && i_addr_lo[0]) ||
                                  (i_store_control == ST_SW && i_addr_lo != 2'b00))
                               : ((w_half_ld && i_addr_lo[0]) ||
                                  (i_load_control == LD_LW && i_addr_lo != 2'b00));

    assign w_byte = i_rdata[{i_off_q, 3'b000} +: 8];
    assign w_half = i_off_q[1] ? i_rdata[31:16] : i_rdata[15:0];

    assign o_rdata = i_ld_q == LD_LB  ? {{24{w_byte[7]}}, w_byte} :
                     i_ld_q == LD_LBU ? {24'd0, w_byte} :
                     i_ld_q == LD_LH  ? {{16{w_half[15]}}, w_half} :
                     i_ld_q == LD_LHU ? {16'd0, w_half} :
                     i_ld_q == LD_LW  ? i_rdata : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between data accesses (fixed priority) and instruction fetch
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clock,
    input logic               nReset,
    mem_port_arbiter_if.slave bus
);

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_ld;
    logic [1:0]  r_off;
    logic        w_store;
    logic        w_dm_req;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

    assign w_store  = bus.store_control != ST_NONE;
    assign w_dm_req = w_store || bus.load_control != LD_NONE;
    assign bus.stall = r_state == DM_BUSY || r_state == IF_BUSY ||
                       (r_state == IDLE && (w_dm_req || bus.if_req));

    mem_lane_align u_align (
        .i_load_control  (bus.load_control),
        .i_store_control (bus.store_control),
        .i_addr_lo       (bus.dm_addr[1:0]),
        .i_wdata         (bus.dm_wdata),
        .i_ld_q          (r_ld),
        .i_off_q         (r_off),
        .i_rdata         (bus.mem_rdata),
        .o_be            (w_be),
        .o_wdata         (w_wdata),
        .o_rdata         (w_rdata),
        .o_misaligned    (w_misaligned)
    );

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_ld          <= LD_NONE;
            r_off         <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.if_valid  <= 1'b0;
            bus.dm_valid  <= 1'b0;
            bus.bus_error <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
        end else begin
            bus.if_valid  <= 1'b0;
            bus.dm_valid  <= 1'b0;
            bus.bus_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_dm_req) begin
                        // Load code and lane offset are kept so a withdrawn request still extracts correctly
                        r_ld  <= w_store ? LD_NONE : bus.load_control;
                        r_off <= bus.dm_addr[1:0];
                        if (w_misaligned) begin
                            r_state       <= DONE;
                            bus.dm_valid  <= 1'b1;
                            bus.bus_error <= 1'b1;
                            bus.dm_rdata  <= '0;
                        end else begin
                            r_state       <= DM_BUSY;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= w_store;
                            bus.mem_addr  <= bus.dm_addr & 32'hFFFF_FFFC;
                            bus.mem_wdata <= w_wdata;
                            bus.mem_be    <= w_be;
                        end
                    end else if (bus.if_req) begin
                        r_state      <= IF_BUSY;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= bus.if_addr & 32'hFFFF_FFFC;
                        bus.mem_be   <= 4'b1111;
                    end
                end
                DM_BUSY, IF_BUSY: begin
                    if (bus.mem_ack || r_cnt == 8'(TIMEOUT - 1)) begin
                        r_state       <= DONE;
                        bus.mem_req   <= 1'b0;
                        bus.bus_error <= !bus.mem_ack;
                        if (r_state == DM_BUSY) begin
                            bus.dm_valid <= 1'b1;
                            bus.dm_rdata <= bus.mem_ack ? w_rdata : '0;
                        end else begin
                            bus.if_valid <= 1'b1;
                            bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for mem_ack before abort (range 1..255).
REQ-002 SHALL have port clock  input  1  single rising-edge clock.
REQ-003 SHALL have port nReset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port if_req  input  1  instruction fetch request, level, held until if_valid.
REQ-005 SHALL have port if_addr  input  32  fetch address, word-aligned.
REQ-006 SHALL have port load_control  input  3  decoder load code (NONE/LB/LH/LW/LBU/LHU).
REQ-007 SHALL have port store_control  input  2  decoder store code (NONE/SB/SH/SW).
REQ-008 SHALL have port dm_addr  input  32  data address from ALU.
REQ-009 SHALL have port dm_wdata  input  32  store data, value in low bits.
REQ-010 SHALL have ports if_rdata  output  32  fetched word; if_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports dm_rdata  output  32  extended load result; dm_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports stall  output  1  core hold; bus_error  output  1  one-cycle pulse on timeout or misalignment.
REQ-013 SHALL have ports mem_req, mem_we  output  1 each; mem_addr  output  32 (word-aligned); mem_wdata  output  32; mem_be  output  4.
REQ-014 SHALL have ports mem_ack  input  1; mem_rdata  input  32.

Function
REQ-015 Data request = load_control!=NONE or store_control!=NONE; both nonzero is illegal, store wins.
REQ-016 FSM states IDLE, DM_BUSY, IF_BUSY, DONE.
REQ-017 IDLE: data request -> DM_BUSY; else if_req -> IF_BUSY; else stay. Data has fixed priority.
REQ-018 mem_req, mem_we, mem_addr, mem_wdata, mem_be registered on IDLE exit, held stable while in BUSY.
REQ-019 BUSY: mem_ack high at edge -> capture result, assert matching *_valid for exactly the next cycle (DONE), then IDLE.
REQ-020 mem_req deasserted in DONE; minimum access latency request-to-valid = 2 cycles with ack on first BUSY cycle.
REQ-021 stall = pending request not yet completed, combinational; low during valid cycle.
REQ-022 mem_be: SB 0001<<addr[1:0]; SH 0011<<(addr[1]*2); SW/loads/fetch 1111.
REQ-023 mem_wdata: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-024 Loads: select byte/half by dm_addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
REQ-025 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no mem_req, go DONE, dm_valid and bus_error pulse, dm_rdata=0.
REQ-026 8-bit wait counter cleared on BUSY entry, increments per BUSY cycle; reaching TIMEOUT without ack -> drop mem_req, DONE, valid plus bus_error, rdata=0.
REQ-027 mem_ack outside BUSY is ignored.
REQ-028 Request withdrawn during BUSY: access still completes; valid pulse still issued.

Reset
REQ-029 nReset low asynchronously forces IDLE; mem_req, mem_we, if_valid, dm_valid, bus_error, stall-state, counter = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; mem_be = 0000.
REQ-030 Reset mid-access abandons it; no valid pulse after release; first post-reset arbitration in the first clock edge with nReset high.

Structure
REQ-031 Load/store code constants and FSM state enum SHALL live in the shared opcode/ALU-code package used by the decoder.
REQ-032 Byte-lane logic (REQ-022..024) SHALL be one sub-module mem_lane_align; FSM and counter stay in the top.

Verification
REQ-033 if_req=1, if_addr=0x100, ack after 1 cycle, rdata=0x00A00093 -> mem_addr=0x100, be=1111, if_valid pulse, if_rdata=0x00A00093.
REQ-034 if_req and LB at 0x203 simultaneously, mem_rdata=0x80FFFFFF -> data first, dm_rdata=0xFFFFFF80, then fetch served.
REQ-035 SH dm_addr=0x12, wdata=0x0000BEEF -> mem_we=1, be=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x10.
REQ-036 LW at 0x101 -> no mem_req, dm_valid+bus_error same cycle, dm_rdata=0.
REQ-037 TIMEOUT=4, mem_ack held 0 -> mem_req drops after 4 BUSY cycles, bus_error pulse, stall low next cycle.
REQ-038 nReset low during DM_BUSY -> mem_req 0 immediately, no dm_valid after release.
